// File: rtl/handhold_pkg.sv
// Shared widths, table entry type and coordinate helpers for the handhold table.
package handhold_pkg;

  localparam int WX = 12;
  localparam int WY = 13;
  localparam int WC = 14;

  typedef struct packed {
    logic                 enable;
    logic signed [WX-1:0] x;
    logic signed [WY-1:0] y;
  } hold_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic logic signed [WC-1:0] ext_x(input logic signed [WX-1:0] v);
    return {{(WC-WX){v[WX-1]}}, v};
  endfunction

  function automatic logic signed [WC-1:0] ext_y(input logic signed [WY-1:0] v);
    return {{(WC-WY){v[WY-1]}}, v};
  endfunction

  // World-to-screen conversion; operands are pre-extended so the difference cannot wrap.
  function automatic logic signed [WC-1:0] to_screen(input logic signed [WC-1:0] pos,
                                                     input logic signed [WC-1:0] origin);
    return pos - origin;
  endfunction

endpackage

// File: rtl/hold_box_hit.sv
// Combinational test of an unsigned pixel against one screen-relative hold square.
module hold_box_hit
  import handhold_pkg::*;
#(
  parameter int HOLD_SIZE = 32
) (
  input  logic signed [WC-1:0] sx,
  input  logic signed [WC-1:0] sy,
  input  logic [10:0]          px,
  input  logic [9:0]           py,
  input  logic                 enable,
  output logic                 hit
);

  localparam logic signed [WC+1:0] HS = (WC+2)'(HOLD_SIZE);

  logic signed [WC+1:0] dx;
  logic signed [WC+1:0] dy;

  // Offsets of the pixel from the square corner, two guard bits so sx+HOLD_SIZE never wraps.
  always_comb begin
    dx  = $signed({5'd0, px}) - $signed({{2{sx[WC-1]}}, sx});
    dy  = $signed({6'd0, py}) - $signed({{2{sy[WC-1]}}, sy});
    hit = enable && !dx[WC+1] && (dx < HS) && !dy[WC+1] && (dy < HS);
  end

endmodule

// File: rtl/handhold_table.sv
// Handhold store: runtime-loaded hold table, per-pixel exists flag and per-frame hand scan with grip latch.
module handhold_table
  import handhold_pkg::*;
#(
  parameter int NUM_HOLDS = 16,
  parameter int HOLD_SIZE = 32,
  parameter int IDX_W     = $clog2(NUM_HOLDS)
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic                 vsync,
  input  logic signed [WX-1:0] screenx,
  input  logic signed [WY-1:0] screeny,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic signed [WX-1:0] wr_x,
  input  logic signed [WY-1:0] wr_y,
  input  logic                 wr_enable,
  input  logic [10:0]          hand1x,
  input  logic [10:0]          hand2x,
  input  logic [9:0]           hand1y,
  input  logic [9:0]           hand2y,
  input  logic                 grab1,
  input  logic                 grab2,
  output logic                 exists,
  output logic                 scan_done,
  output logic                 over1,
  output logic                 over2,
  output logic [IDX_W-1:0]     over1_idx,
  output logic [IDX_W-1:0]     over2_idx,
  output logic                 held1,
  output logic                 held2,
  output logic [IDX_W-1:0]     held1_idx,
  output logic [IDX_W-1:0]     held2_idx
);

  localparam logic [IDX_W:0]   DEPTH    = (IDX_W+1)'(NUM_HOLDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HOLDS - 1);

  hold_t                tbl [NUM_HOLDS];
  logic [NUM_HOLDS-1:0] hit_now;
  logic [NUM_HOLDS-1:0] hit_vec;

  scan_state_t          state;
  logic                 vsync_prev;
  logic [IDX_W-1:0]     idx;
  logic signed [WX-1:0] snap_screenx;
  logic signed [WY-1:0] snap_screeny;
  logic [10:0]          snap_h1x;
  logic [10:0]          snap_h2x;
  logic [9:0]           snap_h1y;
  logic [9:0]           snap_h2y;
  logic                 found1;
  logic                 found2;
  logic [IDX_W-1:0]     found1_idx;
  logic [IDX_W-1:0]     found2_idx;
  logic                 nxt_found1;
  logic                 nxt_found2;
  logic [IDX_W-1:0]     nxt_found1_idx;
  logic [IDX_W-1:0]     nxt_found2_idx;

  hold_t                cur;
  logic signed [WC-1:0] scan_sx;
  logic signed [WC-1:0] scan_sy;
  logic                 scan_hit1;
  logic                 scan_hit2;

  // Table storage: only enable bits are cleared by reset, positions keep their contents.
  always_ff @(posedge vclock) begin
    if (reset) begin
      for (int i = 0; i < NUM_HOLDS; i++) begin
        tbl[i].enable <= 1'b0;
      end
    end else if (wr_en && ({1'b0, wr_idx} < DEPTH)) begin
      tbl[wr_idx] <= '{enable: wr_enable, x: wr_x, y: wr_y};
    end
  end

  for (genvar g = 0; g < NUM_HOLDS; g++) begin : g_render
    logic signed [WC-1:0] sx;
    logic signed [WC-1:0] sy;
    assign sx = to_screen(ext_x(tbl[g].x), ext_x(screenx));
    assign sy = to_screen(ext_y(tbl[g].y), ext_y(screeny));
    hold_box_hit #(.HOLD_SIZE(HOLD_SIZE)) u_hit (
      .sx    (sx),
      .sy    (sy),
      .px    (hcount),
      .py    (vcount),
      .enable(tbl[g].enable),
      .hit   (hit_now[g])
    );
  end

  // Two-stage render pipeline: per-hold hit vector, then its OR.
  always_ff @(posedge vclock) begin
    if (reset) begin
      hit_vec <= '0;
      exists  <= 1'b0;
    end else begin
      hit_vec <= hit_now;
      exists  <= |hit_vec;
    end
  end

  // The scan tests one entry per cycle against the snapshot taken at frame start.
  assign cur     = tbl[idx];
  assign scan_sx = to_screen(ext_x(cur.x), ext_x(snap_screenx));
  assign scan_sy = to_screen(ext_y(cur.y), ext_y(snap_screeny));

  hold_box_hit #(.HOLD_SIZE(HOLD_SIZE)) u_scan_hit1 (
    .sx    (scan_sx),
    .sy    (scan_sy),
    .px    (snap_h1x),
    .py    (snap_h1y),
    .enable(cur.enable),
    .hit   (scan_hit1)
  );

  hold_box_hit #(.HOLD_SIZE(HOLD_SIZE)) u_scan_hit2 (
    .sx    (scan_sx),
    .sy    (scan_sy),
    .px    (snap_h2x),
    .py    (snap_h2y),
    .enable(cur.enable),
    .hit   (scan_hit2)
  );

  // First hit per hand sticks, so the lowest index wins.
  always_comb begin
    nxt_found1     = found1;
    nxt_found1_idx = found1_idx;
    nxt_found2     = found2;
    nxt_found2_idx = found2_idx;
    if (scan_hit1 && !found1) begin
      nxt_found1     = 1'b1;
      nxt_found1_idx = idx;
    end else begin
      nxt_found1     = found1;
      nxt_found1_idx = found1_idx;
    end
    if (scan_hit2 && !found2) begin
      nxt_found2     = 1'b1;
      nxt_found2_idx = idx;
    end else begin
      nxt_found2     = found2;
      nxt_found2_idx = found2_idx;
    end
  end

  // Frame scan FSM; results are registered on the last SCAN edge so they appear with scan_done.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state        <= ST_IDLE;
      vsync_prev   <= 1'b1;
      idx          <= '0;
      snap_screenx <= '0;
      snap_screeny <= '0;
      snap_h1x     <= '0;
      snap_h1y     <= '0;
      snap_h2x     <= '0;
      snap_h2y     <= '0;
      found1       <= 1'b0;
      found2       <= 1'b0;
      found1_idx   <= '0;
      found2_idx   <= '0;
      scan_done    <= 1'b0;
      over1        <= 1'b0;
      over2        <= 1'b0;
      over1_idx    <= '0;
      over2_idx    <= '0;
    end else begin
      vsync_prev <= vsync;
      case (state)
        ST_IDLE: begin
          scan_done <= 1'b0;
          if (vsync_prev && !vsync) begin
            state        <= ST_SCAN;
            idx          <= '0;
            found1       <= 1'b0;
            found2       <= 1'b0;
            snap_screenx <= screenx;
            snap_screeny <= screeny;
            snap_h1x     <= hand1x;
            snap_h1y     <= hand1y;
            snap_h2x     <= hand2x;
            snap_h2y     <= hand2y;
          end
        end
        ST_SCAN: begin
          found1     <= nxt_found1;
          found1_idx <= nxt_found1_idx;
          found2     <= nxt_found2;
          found2_idx <= nxt_found2_idx;
          if (idx == LAST_IDX) begin
            state     <= ST_DONE;
            scan_done <= 1'b1;
            over1     <= nxt_found1;
            over1_idx <= nxt_found1_idx;
            over2     <= nxt_found2;
            over2_idx <= nxt_found2_idx;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          scan_done <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          scan_done <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Grip latch: a falling grab always releases; acquisition happens only in DONE.
  always_ff @(posedge vclock) begin
    if (reset) begin
      held1     <= 1'b0;
      held1_idx <= '0;
      held2     <= 1'b0;
      held2_idx <= '0;
    end else begin
      if (!grab1) begin
        held1 <= 1'b0;
      end else if (state == ST_DONE && !held1 && found1) begin
        held1     <= 1'b1;
        held1_idx <= found1_idx;
      end else begin
        held1     <= held1;
        held1_idx <= held1_idx;
      end
      if (!grab2) begin
        held2 <= 1'b0;
      end else if (state == ST_DONE && !held2 && found2) begin
        held2     <= 1'b1;
        held2_idx <= found2_idx;
      end else begin
        held2     <= held2;
        held2_idx <= held2_idx;
      end
    end
  end

endmodule

// File: tb/tb_handhold_table.sv
// Directed bench for handhold_table: cycle-level behavioural model plus hand-computed expectations.
module tb_handhold_table;
  import handhold_pkg::*;

  localparam int N  = 16;
  localparam int HS = 32;
  localparam int IW = 4;

  logic              vclock = 1'b0;
  logic              reset  = 1'b1;
  logic [10:0]       hcount = '0;
  logic [9:0]        vcount = '0;
  logic              vsync  = 1'b1;
  logic signed [11:0] screenx = '0;
  logic signed [12:0] screeny = '0;
  logic              wr_en = 1'b0;
  logic [IW-1:0]     wr_idx = '0;
  logic signed [11:0] wr_x = '0;
  logic signed [12:0] wr_y = '0;
  logic              wr_enable = 1'b0;
  logic [10:0]       hand1x = '0, hand2x = '0;
  logic [9:0]        hand1y = '0, hand2y = '0;
  logic              grab1 = 1'b0, grab2 = 1'b0;
  logic              exists, scan_done, over1, over2, held1, held2;
  logic [IW-1:0]     over1_idx, over2_idx, held1_idx, held2_idx;

  handhold_table #(.NUM_HOLDS(N), .HOLD_SIZE(HS), .IDX_W(IW)) dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .screenx(screenx), .screeny(screeny), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_enable(wr_enable),
    .hand1x(hand1x), .hand2x(hand2x), .hand1y(hand1y), .hand2y(hand2y),
    .grab1(grab1), .grab2(grab2), .exists(exists), .scan_done(scan_done),
    .over1(over1), .over2(over2), .over1_idx(over1_idx), .over2_idx(over2_idx),
    .held1(held1), .held2(held2), .held1_idx(held1_idx), .held2_idx(held2_idx)
  );

  always #5 vclock = ~vclock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, got, want, $time);
    end
  endtask

  // Behavioural model state
  int m_en [N];
  int m_x  [N];
  int m_y  [N];
  bit ex_d1, m_exists, m_done, m_over1, m_over2, m_held1, m_held2;
  int m_over1_idx, m_over2_idx, m_held1_idx, m_held2_idx;
  bit busy, m_vprev, f1, f2, started;
  int s_cyc, cyc, f1i, f2i, snx, sny, h1x, h1y, h2x, h2y;

  function automatic bit mhit(int i, int px, int py, int scx, int scy);
    int sx, sy;
    sx = m_x[i] - scx;
    sy = m_y[i] - scy;
    return (m_en[i] != 0) && px >= sx && px < sx + HS && py >= sy && py < sy + HS;
  endfunction

  always @(posedge vclock) begin : model
    bit any, in_done;
    int e;
    started = 1'b1;
    if (reset) begin
      for (int j = 0; j < N; j++) m_en[j] = 0;
      ex_d1 = 0; m_exists = 0; m_done = 0;
      m_over1 = 0; m_over2 = 0; m_held1 = 0; m_held2 = 0;
      busy = 0; m_vprev = 1; f1 = 0; f2 = 0;
    end else begin
      any = 0;
      for (int j = 0; j < N; j++) if (mhit(j, hcount, vcount, screenx, screeny)) any = 1;
      m_exists = ex_d1;
      ex_d1    = any;
      in_done  = busy && (cyc == s_cyc + N + 1);
      if (!grab1) m_held1 = 0;
      else if (in_done && !m_held1 && f1) begin m_held1 = 1; m_held1_idx = f1i; end
      if (!grab2) m_held2 = 0;
      else if (in_done && !m_held2 && f2) begin m_held2 = 1; m_held2_idx = f2i; end
      m_done = 0;
      if (busy && cyc >= s_cyc + 1 && cyc <= s_cyc + N) begin
        e = cyc - s_cyc - 1;
        if (!f1 && mhit(e, h1x, h1y, snx, sny)) begin f1 = 1; f1i = e; end
        if (!f2 && mhit(e, h2x, h2y, snx, sny)) begin f2 = 1; f2i = e; end
        if (cyc == s_cyc + N) begin
          m_done = 1;
          m_over1 = f1; m_over1_idx = f1i;
          m_over2 = f2; m_over2_idx = f2i;
        end
      end
      if (in_done) busy = 0;
      else if (!busy && m_vprev && !vsync) begin
        busy = 1; s_cyc = cyc; f1 = 0; f2 = 0;
        snx = screenx; sny = screeny;
        h1x = hand1x; h1y = hand1y; h2x = hand2x; h2y = hand2y;
      end
      m_vprev = vsync;
      if (wr_en && wr_idx < N) begin
        m_en[wr_idx] = wr_enable;
        m_x[wr_idx]  = wr_x;
        m_y[wr_idx]  = wr_y;
      end
    end
    cyc++;
  end

  always @(negedge vclock) begin
    if (started) begin
      check("exists", exists, m_exists);
      check("scan_done", scan_done, m_done);
      check("over1", over1, m_over1);
      check("over2", over2, m_over2);
      if (m_over1) check("over1_idx", over1_idx, m_over1_idx);
      if (m_over2) check("over2_idx", over2_idx, m_over2_idx);
      check("held1", held1, m_held1);
      check("held2", held2, m_held2);
      if (m_held1) check("held1_idx", held1_idx, m_held1_idx);
      if (m_held2) check("held2_idx", held2_idx, m_held2_idx);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge vclock);
      #1;
    end
  endtask

  task automatic write_hold(input int i, input int x, input int y, input bit en);
    wr_en = 1'b1; wr_idx = IW'(i); wr_x = 12'(x); wr_y = 13'(y); wr_enable = en;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (scan_done === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run_scan(output int n);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    wait_done(n);
  endtask

  initial begin
    int n, pulses;
    tick(3);
    reset = 1'b0;
    check("rst_exists", exists, 0);
    check("rst_scan_done", scan_done, 0);
    check("rst_over1", over1, 0);
    check("rst_held1", held1, 0);

    // Basic render hits and edges of the square
    write_hold(0, 150, 50, 1'b1);
    hcount = 11'd150; vcount = 10'd50; tick(2);
    check("t1_corner", exists, 1);
    hcount = 11'd182; tick(2);
    check("t1_right_edge", exists, 0);
    hcount = 11'd181; vcount = 10'd81; tick(2);
    check("t1_far_corner", exists, 1);

    // Scrolling
    write_hold(3, 300, -1000, 1'b1);
    screeny = -13'sd1050; hcount = 11'd300; vcount = 10'd50; tick(2);
    check("t2_scrolled_in", exists, 1);
    screeny = 13'sd0; tick(2);
    check("t2_scrolled_out", exists, 0);
    screeny = -13'sd1050;
    write_hold(3, 300, -1000, 1'b0);
    tick(2);
    check("t2_disabled", exists, 0);
    screeny = 13'sd0;

    // Overlap: lowest index wins
    write_hold(2, 690, 390, 1'b1);
    write_hold(5, 680, 380, 1'b1);
    hand1x = 11'd700; hand1y = 10'd400; hand2x = 11'd10; hand2y = 10'd10;
    run_scan(n);
    check("t3_latency", n, 17);
    check("t3_over1", over1, 1);
    check("t3_over1_idx", over1_idx, 2);
    check("t3_over2", over2, 0);

    // Grab, hold after moving off, release
    grab1 = 1'b1;
    run_scan(n);
    tick();
    check("t4_held1", held1, 1);
    check("t4_held1_idx", held1_idx, 2);
    hand1x = 11'd10; hand1y = 10'd10;
    run_scan(n);
    check("t4_over1_off", over1, 0);
    tick();
    check("t4_still_held", held1, 1);
    grab1 = 1'b0; tick();
    check("t4_released", held1, 0);

    // Grab falls in DONE: clear wins
    hand1x = 11'd700; hand1y = 10'd400; grab1 = 1'b1;
    run_scan(n);
    check("t5_over1", over1, 1);
    grab1 = 1'b0; tick();
    check("t5_race_held1", held1, 0);

    // Second vsync edge mid-scan is ignored
    vsync = 1'b1; tick(); vsync = 1'b0; tick(6);
    vsync = 1'b1; tick(); vsync = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (scan_done === 1'b1) pulses++;
    end
    check("t5_one_pulse", pulses, 1);

    // Write during scan to a not-yet-tested entry is seen
    grab2 = 1'b1;
    vsync = 1'b1; tick(); vsync = 1'b0; tick();
    write_hold(9, 0, 0, 1'b1);
    wait_done(n);
    check("t6_over2", over2, 1);
    check("t6_over2_idx", over2_idx, 9);
    check("t6_over1_idx", over1_idx, 2);
    tick();
    check("t6_held2", held2, 1);
    check("t6_held2_idx", held2_idx, 9);

    // Reset mid-scan at idx 7, then a fresh full scan
    vsync = 1'b1; tick(); vsync = 1'b0; tick(8);
    reset = 1'b1; vsync = 1'b1; tick(); reset = 1'b0;
    check("t7_over1", over1, 0);
    check("t7_over2", over2, 0);
    check("t7_held2", held2, 0);
    check("t7_scan_done", scan_done, 0);
    write_hold(2, 690, 390, 1'b1);
    run_scan(n);
    check("t7_latency", n, 17);
    check("t7_over1", over1, 1);
    check("t7_over1_idx", over1_idx, 2);
    check("t7_over2_cleared", over2, 0);
    grab2 = 1'b0; vsync = 1'b1;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/handhold_table.md
# handhold_table

Parametrised handhold store and tester for the climbing wall. It holds a runtime-loadable table of up to NUM_HOLDS holds in world coordinates, each with an enable bit. Every pixel it renders a registered `exists` flag for the video pipeline. Once per frame it scans the table to find which hold is under each user hand, and it latches a grabbed-hold index per hand. It sits between the video/position bus and the climber physics and pixel mixer.

## Interface
Parameters:
- NUM_HOLDS, 16: table depth; 2..64.
- HOLD_SIZE, 32: hold square side in pixels; power of two not required.
- IDX_W, $clog2(NUM_HOLDS): hold index width.

Ports:
- vclock  in  1: pixel clock; single clock domain.
- reset  in  1: synchronous, active-high.
- hcount  in  11, vcount  in  10: current pixel.
- vsync  in  1: active-low vertical sync.
- screenx  in  signed 12, screeny  in  signed 13: world coordinate of screen origin.
- wr_en  in  1: table write strobe.
- wr_idx  in  IDX_W: entry written.
- wr_x  in  signed 12, wr_y  in  signed 13: world position of the hold's top-left corner.
- wr_enable  in  1: enable bit written with the entry.
- hand1x, hand2x  in  11; hand1y, hand2y  in  10: hand screen positions.
- grab1, grab2  in  1: user grab request, level.
- exists  out  1: current pixel (2 cycles earlier) lies inside an enabled hold.
- scan_done  out  1: one-cycle pulse when hand results publish.
- over1, over2  out  1: hand k is over an enabled hold (last scan).
- over1_idx, over2_idx  out  IDX_W: lowest-index hold under hand k.
- held1, held2  out  1: hand k is gripping a hold.
- held1_idx, held2_idx  out  IDX_W: index of the gripped hold.

## Operation
- Screen-relative hold position:
  - sx = x − screenx and sy = y − screeny, both computed as 14-bit signed.
  - Hit test: px,py are zero-extended to 14 bits signed. A point hits when sx ≤ px < sx+HOLD_SIZE and sy ≤ py < sy+HOLD_SIZE, and the enable bit is 1.
- Table:
  - A write takes effect at the next edge.
  - Reset clears every enable bit; x/y contents are not reset.
  - A write with wr_idx ≥ NUM_HOLDS is ignored.
- Render path:
  - Stage 1 registers the per-hold hit vector for (hcount, vcount) against live screenx/screeny.
  - Stage 2 registers the OR of that vector into `exists`.
- Scan FSM, states IDLE, SCAN, DONE:
  - IDLE → SCAN on a vsync 1→0 edge, detected with a registered previous vsync. Entering SCAN snapshots screenx, screeny, hand1/2 x/y, and sets idx=0 and found1=found2=0.
  - SCAN tests entry idx against both snapshot hands. At the first hit per hand it records the index and sets found. Later hits do not overwrite, so the lowest index wins.
  - SCAN advances idx. After idx=NUM_HOLDS−1 it goes to DONE.
  - DONE publishes found/idx to over*/over*_idx, pulses scan_done, and returns to IDLE.
  - A vsync edge outside IDLE is ignored.
  - Table writes during SCAN are visible only to entries not yet tested.
- Grab latch, per hand k, evaluated every cycle:
  - If grab_k=0: held_k ← 0.
  - Else if DONE and held_k=0 and found_k: held_k ← 1 and held_k_idx ← found index.
  - Else held_k and held_k_idx hold their values. A gripped hold stays gripped even if the hand leaves it or the entry is disabled.
  - If grab_k falls in the DONE cycle, the clear wins.
- Reset, including mid-scan: FSM → IDLE. All outputs, over*_idx and held*_idx are 0, and the previous-vsync register is set to 1.

## Timing
- exists latency: 2 cycles from hcount/vcount.
- scan_done: asserted NUM_HOLDS+1 cycles after the cycle in which the vsync 1→0 edge is detected (1 cycle in IDLE→SCAN, NUM_HOLDS in SCAN, then DONE).
- over*: update in the same cycle scan_done is high and remain stable until the next DONE.
- held* acquire: visible the cycle after DONE. Release: 1 cycle after grab falls.

## Structure
- Package handhold_pkg:
  - Widths: WX=12, WY=13, WC=14.
  - Typedef hold_t {enable, signed x, signed y}.
  - Function to_screen(), which returns the 14-bit screen-relative coordinate.
- Sub-module hold_box_hit (combinational point-in-square test, parameter HOLD_SIZE):
  - NUM_HOLDS instances in the render path.
  - 2 instances in the scan path, muxed by idx.

## Test plan
- Load hold 0 at (150,50) enabled, screen (0,0). hcount=150,vcount=50 → exists=1 two cycles later. hcount=182 → 0. hcount=181,vcount=81 → 1.
- Scroll: hold 3 at (300,−1000), screeny=−1050. Pixel (300,50) → exists=1. screeny=0 → 0. Disable hold 3 → 0.
- Overlap: holds 2 and 5 both cover hand1=(700,400), NUM_HOLDS=16. Drop vsync → scan_done 17 cycles after the edge-detect cycle, over1=1, over1_idx=2, over2=0.
- Grab: grab1=1 with hand over hold 2 → held1=1, held1_idx=2 after DONE. Move the hand off and scan → held1 stays. grab1=0 → held1=0 next cycle.
- Race: grab1 falls in the DONE cycle → held1 stays 0. A second vsync edge mid-scan → only one scan_done.
- Reset during SCAN at idx=7 → all outputs 0 and FSM idle next cycle. A subsequent vsync edge produces a full fresh scan.
